br_wb_arb: RTL
==============

BR_WB_ARB -- requirements
Module: br_wb_arb

Interface
REQ-001 SHALL have parameters: DW, default 32, data width; AW, default 5, register address width (2**AW registers).
REQ-002 SHALL have ports (name  direction  width  meaning):
 clk  in  1  single clock, rising edge
 rst_n  in  1  asynchronous active-low reset
 stall  in  1  freeze: no grants, no register-file writes
 a_valid  in  1  requester A (ALU writeback) has a write
 a_addr  in  AW  A destination register
 a_data  in  DW  A write data
 a_ready  out  1  A write accepted this cycle
 b_valid  in  1  requester B (load writeback) has a write
 b_addr  in  AW  B destination register
 b_data  in  DW  B write data
 b_ready  out  1  B write accepted this cycle
 iss_valid  in  1  decode issues an instruction with destination iss_rd
 iss_rd  in  AW  destination register being reserved
 iss_ready  out  1  iss_rd is not busy (reservation may proceed)
 rs1, rs2  in  AW each  source registers being read by decode
 hazard  out  1  rs1 or rs2 has a pending write
 rw  out  1  register-file write enable
 wa  out  AW  register-file write address
 din  out  DW  register-file write data
 busy  out  2**AW  scoreboard, one pending bit per register

Function
REQ-003 SHALL grant at most one requester per cycle; a transfer occurs on a rising edge where x_valid and x_ready are both 1.
REQ-004 SHALL drive a_ready/b_ready combinationally: 0 when stall=1; otherwise, with one valid, ready the valid one; with both valid, ready the one selected by the round-robin pointer ptr.
REQ-005 SHALL flip ptr to the other requester only on an edge where both were valid and a grant occurred; ptr is otherwise unchanged.
REQ-006 SHALL register the granted write: on the transfer edge rw<=1, wa<=addr, din<=data; on any edge without a transfer rw<=0, with wa/din held.
REQ-007 SHALL give write latency of exactly one cycle: a write accepted at edge t is presented to the register file during cycle t+1.
REQ-008 SHALL discard writes to address 0: the handshake completes, rw<=0, and busy[0] is unchanged.
REQ-009 SHALL set busy[iss_rd] on an edge with iss_valid=1 and iss_ready=1, unless iss_rd=0; busy[0] is always 0.
REQ-010 SHALL drive iss_ready = ~busy[iss_rd] combinationally, independent of stall.
REQ-011 SHALL clear busy[addr] on the transfer edge of a write to addr, so the bit is low in the same cycle that rw=1 presents the data.
REQ-012 SHALL, when a set and a clear target the same register on one edge, let the set win (bit stays 1).
REQ-013 SHALL drive hazard = busy[rs1] | busy[rs2] combinationally.
REQ-014 SHALL, while stall=1, hold ptr and keep rw at 0 from the next edge; scoreboard sets (REQ-009) still occur.
REQ-015 SHALL accept writes to non-busy registers without error; busy stays 0.

Reset
REQ-016 SHALL, on rst_n low, asynchronously clear rw, wa, din and busy to 0 and set ptr to A.
REQ-017 SHALL, on reset asserted mid-transfer, drop the in-flight write (rw=0 immediately); requesters must re-present after reset.
REQ-018 SHALL accept transfers and reservations from the first rising edge after rst_n deasserts.

Structure
REQ-019 SHALL take DW and AW defaults and the requester-select encoding (REQ_A=0, REQ_B=1) from the shared processor package used by the register file.
REQ-020 SHALL be one module; an optional sub-module br_scoreboard (busy vector, set/clear, hazard/iss_ready lookups) is the natural split.

Verification
REQ-021 Single write: issue rd=5, then a_valid with a_addr=5, a_data=0xDEADBEEF -> a_ready=1; next cycle rw=1, wa=5, din=0xDEADBEEF, busy[5]=0.
REQ-022 Contention: a_valid and b_valid held for 4 cycles with addresses 3 and 4 -> grants alternate A,B,A,B; rw=1 in each of the following 4 cycles.
REQ-023 Hazard: issue rd=7; rs1=7 -> hazard=1 and iss_ready=0 for iss_rd=7 until the write to 7 is accepted, then hazard=0 on the following cycle.
REQ-024 Same-edge set/clear: write to 9 accepted on the same edge that iss_valid reserves rd=9 -> busy[9]=1 afterwards.
REQ-025 x0 and stall: write to address 0 -> a_ready=1, rw stays 0; with stall=1 and a_valid=1 -> a_ready=0, rw=0, ptr unchanged.
REQ-026 Reset mid-operation: rst_n low while rw=1 and busy=0x0000_00A0 -> rw=0, busy=0 immediately without a clock edge; the first post-reset grant goes to A when both requesters are valid.

Source files
------------

// File: rtl/br_wb_arb_pkg.sv
// br_wb_arb_pkg: shared processor widths and requester-select encoding
package br_wb_arb_pkg;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
endpackage

// File: rtl/br_scoreboard.sv
// br_scoreboard: per-register pending-write bits with set/clear and hazard lookups
module br_scoreboard
  import br_wb_arb_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en,
  input  logic [AW-1:0]   set_addr,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_addr,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            iss_ready,
  output logic            hazard,
  output logic [2**AW-1:0] busy
);
  localparam int N = 2**AW;
  logic [N-1:0] one, set_v, clr_v;
  assign one = N'(1);
  assign set_v = set_en ? one << set_addr : '0;
  assign clr_v = clr_en ? one << clr_addr : '0;
  assign iss_ready = ~busy[iss_rd];
  assign hazard = busy[rs1] | busy[rs2];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else busy <= ((busy & ~clr_v) | set_v) & ~one;
endmodule

// File: rtl/br_wb_arb.sv
// br_wb_arb: round-robin writeback arbiter with register scoreboard
module br_wb_arb
  import br_wb_arb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             a_valid,
  input  logic [AW-1:0]    a_addr,
  input  logic [DW-1:0]    a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [AW-1:0]    b_addr,
  input  logic [DW-1:0]    b_data,
  output logic             b_ready,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  output logic             iss_ready,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  output logic             hazard,
  output logic             rw,
  output logic [AW-1:0]    wa,
  output logic [DW-1:0]    din,
  output logic [2**AW-1:0] busy
);
  logic ptr, xfer, both;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_data;
  assign both = a_valid & b_valid;
  assign a_ready = ~stall & a_valid & (~b_valid | ptr == REQ_A);
  assign b_ready = ~stall & b_valid & (~a_valid | ptr == REQ_B);
  assign xfer = a_ready | b_ready;
  assign g_addr = b_ready ? b_addr : a_addr;
  assign g_data = b_ready ? b_data : a_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= REQ_A;
      rw <= 1'b0;
      wa <= '0;
      din <= '0;
    end else begin
      rw <= xfer & (g_addr != '0);
      if (xfer) begin
        wa <= g_addr;
        din <= g_data;
      end
      if (xfer & both) ptr <= a_ready ? REQ_B : REQ_A;
    end
  br_scoreboard #(.AW(AW)) u_sb (
    .clk(clk),
    .rst_n(rst_n),
    .set_en(iss_valid & iss_ready),
    .set_addr(iss_rd),
    .clr_en(xfer),
    .clr_addr(g_addr),
    .iss_rd(iss_rd),
    .rs1(rs1),
    .rs2(rs2),
    .iss_ready(iss_ready),
    .hazard(hazard),
    .busy(busy)
  );
endmodule
